// File: rtl/requant_relu_with_mem.sv
// Requantizes M signed accumulator words read over a shared tri-state memory bus
// into saturated DATA_WIDTH activations (optional ReLU, round-half-up shift).
module requant_relu_with_mem #(
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATABUS_WIDTH = 32,
    parameter int unsigned M             = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    src_base,
    input  logic [ADDR_WIDTH-1:0]    dst_base,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic                     mem_sel,
    output logic                     mem_w,
    output logic                     done,
    output logic                     out_valid,
    inout  wire  [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus,
    input  logic                     ready
);

    localparam int unsigned XW = ACC_WIDTH + 1;
    localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
    localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_READ_STALL, S_PROC,
        S_WRITE, S_WRITE_STALL, S_NEXT, S_FINISH
    } state_t;

    state_t                  state, state_d;
    logic                    mem_sel_d, mem_w_d, done_d, out_valid_d;
    logic [KW-1:0]           k;
    logic [ADDR_WIDTH-1:0]   src_q, dst_q, address;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [ACC_WIDTH-1:0]    acc;
    logic [DATABUS_WIDTH-1:0] wdata;
    logic signed [XW-1:0]    x, rnd, y;
    logic [DATA_WIDTH-1:0]   res;

    // State and registered bus/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_sel   <= 1'b0;
            mem_w     <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            mem_sel   <= mem_sel_d;
            mem_w     <= mem_w_d;
            done      <= done_d;
            out_valid <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:        if (start) state_d = S_READ;
            S_READ:        if (ready) state_d = S_READ_STALL;
            S_READ_STALL:  state_d = S_PROC;
            S_PROC:        state_d = S_WRITE;
            S_WRITE:       if (ready) state_d = S_WRITE_STALL;
            S_WRITE_STALL: state_d = S_NEXT;
            S_NEXT:        state_d = (k == KW'(M - 1)) ? S_FINISH : S_READ;
            S_FINISH:      if (!start) state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        mem_sel_d   = (state_d == S_READ) || (state_d == S_WRITE);
        mem_w_d     = (state_d == S_WRITE);
        out_valid_d = (state_d == S_WRITE_STALL);
        done_d      = (state_d == S_FINISH);
    end

    // ReLU, round-half-up arithmetic shift and saturation, one bit wider than acc
    always_comb begin
        x   = (relu_q && acc[ACC_WIDTH-1]) ? '0 : {acc[ACC_WIDTH-1], acc};
        rnd = (shift_q != 5'd0) ? (XW'(1) << (shift_q - 5'd1)) : '0;
        y   = (x + rnd) >>> shift_q;
        if (y > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
        else if (y < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
        else                  res = y[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc     <= '0;
            address <= '0;
            wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    src_q   <= src_base;
                    dst_q   <= dst_base;
                    shift_q <= shift;
                    relu_q  <= relu_en;
                    k       <= '0;
                    address <= src_base;
                end
                S_READ: if (ready) acc <= data_bus[ACC_WIDTH-1:0];
                S_PROC: begin
                    wdata   <= {{(DATABUS_WIDTH - DATA_WIDTH){res[DATA_WIDTH-1]}}, res};
                    address <= dst_q + ADDR_WIDTH'(k);
                end
                S_NEXT: if (k != KW'(M - 1)) begin
                    k       <= k + KW'(1);
                    address <= src_q + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign address_bus = mem_sel ? address : {ADDR_WIDTH{1'bz}};
    assign data_bus    = (mem_sel && mem_w) ? wdata : {DATABUS_WIDTH{1'bz}};

endmodule
